// File: rtl/btn_conditioner.sv
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Five-button synchroniser, debouncer and fixed-width strobe generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 20,
    parameter int         PULSE_CYCLES    = 100,
    parameter int         REPEAT_DELAY    = 500,
    parameter int         REPEAT_PERIOD   = 200,
    parameter logic [4:0] REPEAT_MASK     = 5'b01100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn,
    output logic [4:0] btn_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W = $clog2(PULSE_CYCLES + 1);
    localparam int TM_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [DB_W-1:0] C_DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [PC_W-1:0] C_PULSE_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [TM_W-1:0] C_DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] C_PERIOD_LAST = TM_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_chan
            logic            sync1_q;
            logic            sync2_q;
            logic [DB_W-1:0] db_cnt_q;
            logic            level_q;
            logic            level_d;
            state_t          state_q;
            logic [TM_W-1:0] timer_q;
            logic [PC_W-1:0] pulse_cnt_q;
            logic            btn_q;
            logic            strobe_fire;

            // Level flips once the mismatch count has reached the limit.
            always_comb begin
                level_d = level_q;
                if (db_cnt_q == C_DB_LIMIT) begin
                    level_d = ~level_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    db_cnt_q <= '0;
                    level_q  <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[i];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    if (db_cnt_q == C_DB_LIMIT) begin
                        db_cnt_q <= '0;
                    end else if (sync2_q != level_q) begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end else begin
                        db_cnt_q <= '0;
                    end
                end
            end

            // The FSM looks at next-cycle level so strobe and level rise together.
            always_comb begin
                strobe_fire = 1'b0;
                case (state_q)
                    ST_IDLE:   strobe_fire = level_d;
                    ST_HELD:   strobe_fire = level_d && REPEAT_MASK[i] &&
                                             (timer_q == C_DELAY_LAST);
                    ST_REPEAT: strobe_fire = level_d && (timer_q == C_PERIOD_LAST);
                    default:   strobe_fire = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q     <= ST_IDLE;
                    timer_q     <= '0;
                    pulse_cnt_q <= '0;
                    btn_q       <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (level_d) begin
                                state_q <= ST_HELD;
                                timer_q <= '0;
                            end
                        end
                        ST_HELD: begin
                            if (!level_d) begin
                                state_q <= ST_IDLE;
                            end else if (strobe_fire) begin
                                state_q <= ST_REPEAT;
                                timer_q <= '0;
                            end else if (timer_q != C_DELAY_LAST) begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (!level_d) begin
                                state_q <= ST_IDLE;
                            end else if (strobe_fire) begin
                                timer_q <= '0;
                            end else if (timer_q != C_DELAY_LAST) begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            timer_q <= '0;
                        end
                    endcase

                    if (strobe_fire) begin
                        btn_q       <= 1'b1;
                        pulse_cnt_q <= '0;
                    end else if (btn_q) begin
                        if (pulse_cnt_q == C_PULSE_LAST) begin
                            btn_q       <= 1'b0;
                            pulse_cnt_q <= '0;
                        end else begin
                            pulse_cnt_q <= pulse_cnt_q + 1'b1;
                        end
                    end
                end
            end

            assign btn[i]       = btn_q;
            assign btn_level[i] = level_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Directed stimulus with an event scoreboard for btn_conditioner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn;
    logic [4:0] btn_level;

    btn_conditioner dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn       (btn),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = strobe output, kind 1 = debounced level
    typedef struct {
        int t;
        int kind;
        int idx;
        int val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         t_base  = 0;
    bit         mon_en  = 1'b0;
    logic [4:0] prev_btn;
    logic [4:0] prev_lvl;

    task automatic push_ev(input int t, input int kind, input int idx, input int val);
        ev_t e;
        e.t = t; e.kind = kind; e.idx = idx; e.val = val;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic cur;
        logic old;
        ev_t  e;
        int   rel;
        if (mon_en) begin
            rel = cyc - t_base;
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 5; b++) begin
                    cur = (k == 0) ? btn[b] : btn_level[b];
                    old = (k == 0) ? prev_btn[b] : prev_lvl[b];
                    if (cur !== old) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_event: t=%0d kind=%0d bit=%0d got=%b, required no change",
                                     rel, k, b, cur);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.t != rel || e.kind != k || e.idx != b || e.val != int'(cur)) begin
                                n_fail++;
                                $display("FAIL event: got t=%0d kind=%0d bit=%0d val=%b, required t=%0d kind=%0d bit=%0d val=%0d",
                                         rel, k, b, cur, e.t, e.kind, e.idx, e.val);
                            end
                        end
                    end
                end
            end
        end
        prev_btn = btn;
        prev_lvl = btn_level;
    end

    function automatic logic [4:0] raw_of(input int test, input int c);
        case (test)
            1: return (c < 300)  ? 5'b01000 : 5'b00000;
            2: return (c < 1000) ? 5'b01000 : 5'b00000;
            3: return (c < 1000) ? 5'b10000 : 5'b00000;
            4: begin
                if (c < 100) return (((c / 5) % 2) == 0) ? 5'b00010 : 5'b00000;
                return (c < 300) ? 5'b00010 : 5'b00000;
            end
            5: return (c >= 20 && c < 35) ? 5'b00001 : 5'b00000;
            6: return (c < 600) ? 5'b01100 : 5'b00000;
            7: return (c < 300) ? 5'b00100 : 5'b00000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic run_test(input int test, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == 0) t_base = cyc + 1;
            btn_raw = raw_of(test, c);
            rst     = (test == 7 && c >= 50 && c < 60);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: test=%0d got %0d events still pending, required 0",
                     test, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 5'b00000;
        repeat (4) @(negedge clk);

        n_tests++;
        if (btn !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_btn: got %b, required 00000", btn);
        end
        n_tests++;
        if (btn_level !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_level: got %b, required 00000", btn_level);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (30) @(negedge clk);

        // Single press on up
        push_ev(22, 0, 3, 1); push_ev(22, 1, 3, 1);
        push_ev(122, 0, 3, 0); push_ev(322, 1, 3, 0);
        run_test(1, 400);

        // Auto-repeat on up
        push_ev(22, 0, 3, 1); push_ev(22, 1, 3, 1);
        push_ev(122, 0, 3, 0);
        push_ev(522, 0, 3, 1); push_ev(622, 0, 3, 0);
        push_ev(722, 0, 3, 1); push_ev(822, 0, 3, 0);
        push_ev(922, 0, 3, 1);
        push_ev(1022, 0, 3, 0); push_ev(1022, 1, 3, 0);
        run_test(2, 1200);

        // Centre is not repeat-enabled
        push_ev(22, 0, 4, 1); push_ev(22, 1, 4, 1);
        push_ev(122, 0, 4, 0); push_ev(1022, 1, 4, 0);
        run_test(3, 1200);

        // Bouncing left settles at cycle 100
        push_ev(122, 0, 1, 1); push_ev(122, 1, 1, 1);
        push_ev(222, 0, 1, 0); push_ev(322, 1, 1, 0);
        run_test(4, 400);

        // 15-cycle glitch on right: nothing expected
        run_test(5, 100);

        // Up and down together
        push_ev(22, 0, 2, 1); push_ev(22, 0, 3, 1);
        push_ev(22, 1, 2, 1); push_ev(22, 1, 3, 1);
        push_ev(122, 0, 2, 0); push_ev(122, 0, 3, 0);
        push_ev(522, 0, 2, 1); push_ev(522, 0, 3, 1);
        push_ev(622, 0, 2, 0); push_ev(622, 0, 3, 0);
        push_ev(622, 1, 2, 0); push_ev(622, 1, 3, 0);
        run_test(6, 800);

        // Reset mid-pulse with the button held through it
        push_ev(22, 0, 2, 1); push_ev(22, 1, 2, 1);
        push_ev(50, 0, 2, 0); push_ev(50, 1, 2, 0);
        push_ev(82, 0, 2, 1); push_ev(82, 1, 2, 1);
        push_ev(182, 0, 2, 0); push_ev(322, 1, 2, 0);
        run_test(7, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the five raw push-buttons of the lab board into clean command strobes.
- Output feeds the 5-bit btn input of the alarm/clock-setting blocks.
- Per button: synchronises, debounces, and emits one fixed-width pulse per press.
- Selected buttons (up/down) also auto-repeat while held.
- Pulse width spans exactly one period of the /100 setting clock, so each strobe is seen by exactly one slow-clock edge downstream.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronised samples required before the debounced level changes.
- PULSE_CYCLES, 100: width of each output strobe, in clk cycles.
- REPEAT_DELAY, 500: cycles from the start of the first strobe to the start of the first repeat strobe.
- REPEAT_PERIOD, 200: cycles between the starts of successive repeat strobes.
- REPEAT_MASK, 5'b01100: per-bit auto-repeat enable. Default enables up and down only.

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- btn_raw, input, 5: raw buttons, asynchronous. Bit order {center, up, down, left, right} = [4:0].
- btn, output, 5: conditioned strobes, same bit order.
- btn_level, output, 5: debounced held level, same bit order.

Behaviour:
- Reset:
  - While rst is sampled high: btn=0, btn_level=0, all sync flops, counters and FSMs cleared.
  - Outputs are 0 from the first edge with rst high.
  - Reset mid-pulse truncates the pulse.
  - A button held through reset is treated as a fresh press after reset deasserts.
- Channels are fully independent; simultaneous presses on several buttons produce independent strobes.
- Synchroniser: 2-flop per bit, giving 2 cycles of latency.
- Debounce:
  - The counter increments each cycle the synchronised value differs from btn_level.
  - It clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, btn_level flips and the counter clears.
  - Net effect: a raw change held constant from cycle t flips btn_level (registered) at cycle t+DEBOUNCE_CYCLES+2 (t+22 with defaults).
  - Any raw excursion shorter than DEBOUNCE_CYCLES produces no change.
- Per-channel FSM, states IDLE, HELD, REPEAT:
  - IDLE -> HELD on btn_level rising. A strobe starts in the same cycle btn_level first reads 1, and the repeat timer starts.
  - HELD -> REPEAT when the timer reaches REPEAT_DELAY with the level still 1 and REPEAT_MASK[i]=1. A strobe starts and the timer restarts.
  - REPEAT: a new strobe starts every REPEAT_PERIOD cycles while the level is 1.
  - HELD/REPEAT -> IDLE in the cycle btn_level reads 0. No new strobes start after that.
  - If REPEAT_MASK[i]=0, HELD stays until release and never enters REPEAT.
- Strobe:
  - btn[i] is high for exactly PULSE_CYCLES consecutive cycles.
  - A strobe in progress at release completes its full width.
  - Strobes never overlap; this is guaranteed by the legality constraint below.
- Legal parameters: 1 <= PULSE_CYCLES < REPEAT_PERIOD <= REPEAT_DELAY and DEBOUNCE_CYCLES >= 1. Other values are unsupported.
- Counter widths are sized from the parameters; no counter may wrap during normal operation.
- The repeat timer saturates at its limit if not cleared.

Test Plan:
- Single press: btn_raw[3]=1 for cycles 0..299 -> btn_level[3]=1 cycles 22..321; btn[3]=1 cycles 22..121 only; other bits stay 0.
- Auto-repeat: btn_raw[3]=1 for cycles 0..999 -> strobes start at 22, 522, 722, 922, each 100 wide. The 922 strobe completes through 1021; no strobe at 1122.
- Repeat masked: btn_raw[4]=1 for cycles 0..999 -> exactly one strobe, cycles 22..121; btn_level[4] falls at 1022.
- Bounce and glitch:
  - btn_raw[1] toggles every 5 cycles for cycles 0..99, then held at 1 -> no output before 122; btn_level[1] and strobe at 122 (last toggle at 100).
  - A separate 15-cycle high glitch -> no output at all.
- Simultaneous: btn_raw[3] and btn_raw[2] rise together at cycle 0 and are held 600 cycles -> both bits show identical strobe timing (22, 522).
- Reset mid-pulse:
  - Press btn_raw[2] at 0 and hold. Assert rst for cycles 50..59 -> btn=0 and btn_level=0 from cycle 50.
  - After rst goes low at cycle 60 with the button still held -> new strobe at 60+22=82.
